systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 Parameters: ACT_WIDTH, default 16, FP16 activation width; ACC_WIDTH, default 32, signed accumulator width; N, default 2, array is N x N.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 active  input  1  high for each weight-bit cycle of a run (K*precision cycles).
REQ-005 precision  input  4  weight bit-width, legal range 1..8.
REQ-006 exp_set  input  5  common output exponent (biased, FP16 bias 15).
REQ-007 act_in[N]  input  ACT_WIDTH each  row i activation, FIFO head (first-word-fall-through).
REQ-008 w_in[N]  input  1 each  column j serial weight bit, FIFO head.
REQ-009 done  output  1  one-cycle pulse when all PEs have finished.
REQ-010 exp_out[N*N]  output  5 each  exponent of acc_out, index i*N+j.
REQ-011 acc_out[N*N]  output  ACC_WIDTH each  signed fixed-point result of PE[i][j].
REQ-012 active_row[N]  output  1 each  read enable for row i activation FIFO.
REQ-013 active_column[N]  output  1 each  read enable for column j weight FIFO.

Function
REQ-014 active_row[i] SHALL equal active delayed i cycles; active_column[j] SHALL equal active delayed j cycles (index 0 combinational).
REQ-015 Activations SHALL pass left-to-right and weight bits and valid top-to-bottom through one register per PE, so PE[i][j] processes cycle t's operands at t+i+j.
REQ-016 Weights SHALL be signed two's complement, serialized LSB first, precision bits per weight; bit index p = 0..precision-1 per PE counter, wrapping to 0.
REQ-017 Activation decode: s=bit15, e=bits14:10, m=bits9:0; significand M = {1,m} if e!=0, else {0,m} with e treated as 1.
REQ-018 Aligned term A = (s ? -M : M) shifted left by (e-exp_set) if positive, arithmetic right shift otherwise, computed at ACC_WIDTH; overflow wraps.
REQ-019 Per valid cycle with weight bit 1: acc += A<<p for p<precision-1, acc -= A<<p for p=precision-1; bit 0 leaves acc unchanged.
REQ-020 Result: acc_out = sum_k act_k*w_k*2^(10-(exp_set-15)) with unit scaling (1.0*w gives w*1024 at exp_set=15).
REQ-021 exp_out SHALL equal exp_set captured on the first valid cycle of a run.
REQ-022 Each PE SHALL clear acc and bit counter on its first valid cycle following an idle period, restarting the run.
REQ-023 done SHALL pulse high for one cycle on the cycle after PE[N-1][N-1]'s valid falls (2N-1 cycles after active falls).
REQ-024 acc_out/exp_out SHALL hold between runs until reset or the next run start.
REQ-025 active deasserted mid-weight SHALL freeze the bit counter; resumption continues the same weight.

Reset
REQ-026 rst SHALL clear all acc_out, exp_out, bit counters, pipeline registers, valid flags, done, active_row and active_column to 0 within one cycle, including mid-run.

Structure
REQ-027 Shared package: ACT_WIDTH, ACC_WIDTH, FP16 field positions, exponent bias 15.
REQ-028 One sub-module systolic_pe (single MAC, pass-through registers); systolic_array is generate-instantiated NxN of it plus skew logic.
REQ-029 Companion FIFOs are external: fifo (1-bit weights) and act_fifo (advances one activation per precision reads).

Verification
REQ-030 N=2, precision 4, exp_set 15, row0 acts (0x3C00,0x3C00), row1 (0x4000,0x3C00), col0 w (-5,-5), col1 (-1,-2) -> acc_out = FFFFD800, FFFFF400, FFFFC400, FFFFF000; exp_out all 15.
REQ-031 act 0xBC00, w=3 -> FFFFF400; act 0x3800, w=7 -> 00000E00.
REQ-032 precision 8, act 0x3C00, w=-128 -> FFFE0000.
REQ-033 active high 8 cycles, N=2 -> active_row[1]/active_column[1] lag 1 cycle; done pulses once, 3 cycles after active falls.
REQ-034 rst asserted mid-run -> next cycle all acc_out 0, done 0, enables 0; a fresh run then yields REQ-030 values.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared widths, FP16 field positions and exponent bias for the bit-serial systolic array.
package systolic_array_pkg;
  localparam int ACT_WIDTH  = 16;
  localparam int ACC_WIDTH  = 32;
  localparam int EXP_WIDTH  = 5;
  localparam int PREC_WIDTH = 4;

  localparam int FP16_SIGN_BIT = 15;
  localparam int FP16_EXP_MSB  = 14;
  localparam int FP16_EXP_LSB  = 10;
  localparam int FP16_MAN_MSB  = 9;
  localparam int FP16_BIAS     = 15;
endpackage

// File: rtl/systolic_pe.sv
// One processing element: FP16 activation times a bit-serial signed weight, accumulated at a
// shared output exponent; activation passes right, weight bit and valid pass down, one register each.
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int ACT_WIDTH = systolic_array_pkg::ACT_WIDTH,
  parameter int ACC_WIDTH = systolic_array_pkg::ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PREC_WIDTH-1:0] precision,
  input  logic [EXP_WIDTH-1:0]  exp_set,
  input  logic [ACT_WIDTH-1:0]  act,
  input  logic                  w_bit,
  input  logic                  vld,
  output logic [ACT_WIDTH-1:0]  act_q,
  output logic                  w_q,
  output logic                  vld_q,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [EXP_WIDTH-1:0]  exp_q
);
  logic                  f_sign;
  logic [EXP_WIDTH-1:0]  f_exp;
  logic [FP16_MAN_MSB:0] f_man;
  logic [EXP_WIDTH-1:0]  e_eff;
  logic [ACC_WIDTH-1:0]  mag;
  logic signed [ACC_WIDTH-1:0] signed_m;
  logic signed [ACC_WIDTH-1:0] aligned;
  logic signed [6:0]     sh;
  logic [5:0]            shr;
  logic [PREC_WIDTH-1:0] bit_cnt;
  logic [PREC_WIDTH-1:0] p;
  logic                  start;
  logic                  last;
  logic [ACC_WIDTH-1:0]  term;
  logic [ACC_WIDTH-1:0]  delta;
  logic [ACC_WIDTH-1:0]  acc_nxt;

  assign f_sign = act[FP16_SIGN_BIT];
  assign f_exp  = act[FP16_EXP_MSB:FP16_EXP_LSB];
  assign f_man  = act[FP16_MAN_MSB:0];

  // A new run begins only at a weight boundary, so a pause mid-weight resumes the same weight.
  assign start = vld && !vld_q && (bit_cnt == '0);
  assign p     = start ? '0 : bit_cnt;
  assign last  = (p == precision - PREC_WIDTH'(1));

  always_comb begin
    e_eff    = (f_exp == '0) ? EXP_WIDTH'(1) : f_exp;
    mag      = ACC_WIDTH'({(f_exp != '0), f_man});
    signed_m = f_sign ? -mag : mag;
    sh       = $signed({2'b00, e_eff}) - $signed({2'b00, exp_set});
    shr      = 6'(-sh);
    aligned  = (sh >= 0) ? (signed_m <<< sh[5:0]) : (signed_m >>> shr);
    term     = aligned <<< p;
    delta    = !w_bit ? '0 : (last ? -term : term);
    acc_nxt  = (start ? '0 : acc) + delta;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q   <= '0;
      w_q     <= 1'b0;
      vld_q   <= 1'b0;
      acc     <= '0;
      exp_q   <= '0;
      bit_cnt <= '0;
    end else begin
      act_q <= act;
      w_q   <= w_bit;
      vld_q <= vld;
      if (vld) begin
        acc     <= acc_nxt;
        bit_cnt <= last ? '0 : p + PREC_WIDTH'(1);
      end
      if (start) exp_q <= exp_set;
    end
  end
endmodule

// File: rtl/systolic_array.sv
// N x N bit-serial systolic array: skewed FIFO read enables, PE grid, and a done pulse one
// cycle after the bottom-right PE's valid falls (requires N >= 2).
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int ACT_WIDTH = systolic_array_pkg::ACT_WIDTH,
  parameter int ACC_WIDTH = systolic_array_pkg::ACC_WIDTH,
  parameter int N         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic [PREC_WIDTH-1:0] precision,
  input  logic [EXP_WIDTH-1:0]  exp_set,
  input  logic [ACT_WIDTH-1:0]  act_in [N],
  input  logic [N-1:0]          w_in,
  output logic                  done,
  output logic [EXP_WIDTH-1:0]  exp_out [N*N],
  output logic [ACC_WIDTH-1:0]  acc_out [N*N],
  output logic [N-1:0]          active_row,
  output logic [N-1:0]          active_column
);
  logic [N-2:0]         dly_q;
  logic [N-1:0]         skew;
  logic [ACT_WIDTH-1:0] act_h [N*(N+1)];
  logic                 w_v   [(N+1)*N];
  logic                 vld_v [(N+1)*N];
  logic                 last_in;
  logic                 last_q;

  assign skew          = {dly_q, active & ~rst};
  assign active_row    = skew;
  assign active_column = skew;

  always_ff @(posedge clk) begin
    if (rst) dly_q <= '0;
    else     dly_q <= skew[N-2:0];
  end

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign act_h[i*(N+1)] = act_in[i];
    assign w_v[i]         = w_in[i];
    assign vld_v[i]       = skew[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .ACT_WIDTH (ACT_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .precision (precision),
        .exp_set   (exp_set),
        .act       (act_h[i*(N+1)+j]),
        .w_bit     (w_v[i*N+j]),
        .vld       (vld_v[i*N+j]),
        .act_q     (act_h[i*(N+1)+j+1]),
        .w_q       (w_v[(i+1)*N+j]),
        .vld_q     (vld_v[(i+1)*N+j]),
        .acc       (acc_out[i*N+j]),
        .exp_q     (exp_out[i*N+j])
      );
    end
  end

  assign last_in = vld_v[(N-1)*N + N-1];
  assign last_q  = vld_v[N*N + N-1];

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= last_q & ~last_in;
  end
endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for the 2x2 systolic array with a behavioural FIFO front end.
module tb_systolic_array;
  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic [3:0]  precision;
  logic [4:0]  exp_set;
  logic [15:0] act_in [2];
  logic [1:0]  w_in;
  logic        done;
  logic [4:0]  exp_out [4];
  logic [31:0] acc_out [4];
  logic [1:0]  active_row;
  logic [1:0]  active_column;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [15:0] acts [2][2];
  logic [7:0]  wts  [2][2];
  int   rd_row [2];
  int   rd_col [2];
  int   k_len    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  logic prev_a   = 1'b0;
  bit   lag_ok   = 1'b0;

  always #5 clk = ~clk;

  systolic_array #(.ACT_WIDTH(16), .ACC_WIDTH(32), .N(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .active        (active),
    .precision     (precision),
    .exp_set       (exp_set),
    .act_in        (act_in),
    .w_in          (w_in),
    .done          (done),
    .exp_out       (exp_out),
    .acc_out       (acc_out),
    .active_row    (active_row),
    .active_column (active_column)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock: present FIFO heads, sample outputs, then pop whichever FIFOs were enabled.
  task automatic step(input logic a);
    logic [1:0] en_r, en_c;
    int idx;
    active = a;
    for (int i = 0; i < 2; i++) begin
      idx = rd_row[i] / int'(precision);
      act_in[i] = (idx < k_len) ? acts[i][idx] : 16'h0000;
    end
    for (int j = 0; j < 2; j++) begin
      idx = rd_col[j] / int'(precision);
      w_in[j] = (idx < k_len) ? wts[j][idx][rd_col[j] % int'(precision)] : 1'b0;
    end
    #1;
    if (lag_ok) begin
      check("row1_lag", {31'd0, active_row[1]}, {31'd0, prev_a});
      check("col1_lag", {31'd0, active_column[1]}, {31'd0, prev_a});
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    en_r = active_row;
    en_c = active_column;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (en_r[i]) rd_row[i]++;
      if (en_c[i]) rd_col[i]++;
    end
    prev_a = a & ~rst;
    lag_ok = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int k, input int p, input int pause_at);
    int fall;
    k_len     = k;
    precision = 4'(p);
    for (int i = 0; i < 2; i++) begin
      rd_row[i] = 0;
      rd_col[i] = 0;
    end
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c < k * p; c++) begin
      if (c == pause_at) begin
        step(1'b0);
        step(1'b0);
      end
      step(1'b1);
    end
    fall = cyc;
    for (int c = 0; c < 6; c++) step(1'b0);
    if (pause_at < 0) begin
      check("done_count", done_cnt, 1);
      check("done_latency", done_cyc - fall, 3);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input logic [4:0] ee);
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    for (int q = 0; q < 4; q++) begin
      check($sformatf("%s_acc%0d", tag, q), acc_out[q], ev[q]);
      check($sformatf("%s_exp%0d", tag, q), {27'd0, exp_out[q]}, {27'd0, ee});
    end
  endtask

  task automatic load_base();
    acts[0][0] = 16'h3C00; acts[0][1] = 16'h3C00;
    acts[1][0] = 16'h4000; acts[1][1] = 16'h3C00;
    wts[0][0]  = 8'hFB;    wts[0][1]  = 8'hFB;
    wts[1][0]  = 8'hFF;    wts[1][1]  = 8'hFE;
  endtask

  initial begin
    rst       = 1'b1;
    active    = 1'b0;
    precision = 4'd4;
    exp_set   = 5'd15;
    w_in      = 2'b00;
    act_in[0] = 16'h0000;
    act_in[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      rd_row[i] = 0;
      rd_col[i] = 0;
    end
    @(negedge clk);
    step(1'b0);
    step(1'b0);
    check_res("reset", 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rows", {30'd0, active_row}, 32'd0);
    check("reset_cols", {30'd0, active_column}, 32'd0);
    rst = 1'b0;

    // Two-term dot products with negative weights, 8 active cycles.
    load_base();
    run(2, 4, -1);
    check_res("base", 32'hFFFFD800, 32'hFFFFF400, 32'hFFFFC400, 32'hFFFFF000, 5'd15);

    // Negative activation and a sub-unity activation (right-shift alignment).
    acts[0][0] = 16'hBC00; acts[1][0] = 16'h3800;
    wts[0][0]  = 8'h03;    wts[1][0]  = 8'h07;
    run(1, 4, -1);
    check_res("sign_frac", 32'hFFFFF400, 32'hFFFFE400, 32'h00000600, 32'h00000E00, 5'd15);

    // Eight-bit weights with the most negative value.
    acts[0][0] = 16'h3C00; acts[1][0] = 16'h4000;
    wts[0][0]  = 8'h80;    wts[1][0]  = 8'h05;
    run(1, 8, -1);
    check_res("prec8", 32'hFFFE0000, 32'h00001400, 32'hFFFC0000, 32'h00002800, 5'd15);

    // Mid-weight pause at a raised output exponent.
    exp_set    = 5'd16;
    acts[0][0] = 16'h3C00; acts[1][0] = 16'h3C00;
    wts[0][0]  = 8'h03;    wts[1][0]  = 8'hFF;
    run(1, 4, 2);
    check_res("pause", 32'h00000600, 32'hFFFFFE00, 32'h00000600, 32'hFFFFFE00, 5'd16);

    // Reset in the middle of a run, then a clean rerun.
    exp_set = 5'd15;
    load_base();
    k_len     = 2;
    precision = 4'd4;
    for (int i = 0; i < 2; i++) begin
      rd_row[i] = 0;
      rd_col[i] = 0;
    end
    for (int c = 0; c < 5; c++) step(1'b1);
    rst = 1'b1;
    step(1'b0);
    check_res("midrst", 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_rows", {30'd0, active_row}, 32'd0);
    check("midrst_cols", {30'd0, active_column}, 32'd0);
    rst = 1'b0;
    run(2, 4, -1);
    check_res("rerun", 32'hFFFFD800, 32'hFFFFF400, 32'hFFFFC400, 32'hFFFFF000, 5'd15);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
